iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Parametrised multi-cycle restoring divider: one quotient bit per clock, accumulated in a shift register of width 2*WIDTH.
- Adds over the previous single-width quotient control block:
  - WIDTH generalisation
  - signed/unsigned mode
  - start/ready handshake
  - divide-by-zero and overflow exceptions
  - sign fix-up stage
- Sits in the execute-stage multdiv unit. The pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (must be at least 2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ctrl_div  in  1  start strobe; sampled only in IDLE.
- ctrl_signed  in  1  1 = two's-complement divide, 0 = unsigned; captured with ctrl_div.
- data_operandA  in  WIDTH  dividend; captured with ctrl_div.
- data_operandB  in  WIDTH  divisor; captured with ctrl_div.
- data_quotient  out  WIDTH  quotient; valid while data_resultRDY=1, held until next accepted start.
- data_exception  out  1  divide-by-zero or signed overflow; same validity as data_quotient.
- data_resultRDY  out  1  single-cycle done pulse.
- busy  out  1  high from the cycle after start acceptance until data_resultRDY is asserted.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; all outputs 0; internal registers 0. Reset asserted mid-operation aborts the divide, and no rdy pulse is issued.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE:
  - Accept a start on a clock edge with ctrl_div=1.
  - Latch mag_a and mag_b:
    - mag_a = |A| if ctrl_signed, else A.
    - mag_b = |B| if ctrl_signed, else B.
    - |MIN| is treated as unsigned 2^(WIDTH-1).
  - Latch neg_q = signed & (A[MSB]^B[MSB]).
  - Latch neg_r = signed & A[MSB].
  - Load acc = {WIDTH'0, mag_a}; counter = 0.
  - If B==0: set exc, go to DONE, quotient=0.
  - Otherwise go to ITER.
- ITER, one step per cycle:
  - shifted = acc<<1.
  - diff = shifted[2W-1:W] - mag_b, computed at width W+1.
  - If diff is non-negative: upper half = diff[W-1:0], bit0 = 1.
  - Else: upper half = shifted upper half, bit0 = 0.
  - counter++. After WIDTH steps, go to FIXUP.
- FIXUP (one cycle):
  - quotient = neg_q ? -acc[W-1:0] : acc[W-1:0].
  - remainder = neg_r ? -acc[2W-1:W] : acc[2W-1:W].
  - Signed MIN / -1: quotient = MIN (wrapped), exc = 1.
  - Go to DONE.
- DONE (one cycle): data_resultRDY=1, busy=0, then IDLE.
- Latency:
  - Normal: ctrl_div sampled at edge 0 -> data_resultRDY high in the cycle after edge WIDTH+2.
  - Divide-by-zero: rdy high after edge 1.
- ctrl_div while busy or in DONE: ignored (not queued).
- Back-to-back: a start accepted in the IDLE cycle immediately following DONE is legal.
- Outputs data_quotient and data_exception are registered and hold their values after DONE until the next start is accepted. They are cleared to 0 on acceptance.
- Unsigned mode never sets exc except for B==0.

Optional Feature:
- DIV_REMAINDER_EN defined:
  - Extra output port data_remainder (WIDTH, out).
  - Registered alongside data_quotient with the same validity and hold rules.
  - Sign follows the dividend.
  - Equals A and 0 respectively... (see below)
  - On divide-by-zero: remainder = A.
  - On signed overflow: remainder = 0.
  - Reset value 0.
- Not defined: port and its register absent; the FIXUP remainder logic is removed.

Decomposition:
- Package divider_pkg holds:
  - state typedef div_state_t {IDLE, ITER, FIXUP, DONE}
  - DIV_WIDTH_DEFAULT = 32
  - helper function abs_u(value, signed_mode)
- One sub-module: div_step.
  - Purely combinational single restoring iteration.
  - Inputs: acc (2*WIDTH), divisor (WIDTH).
  - Output: next acc.
  - Parametrised by WIDTH.

Test Plan:
- Unsigned 100 / 7, WIDTH=32:
  - quotient=14, remainder=2, exc=0.
  - rdy exactly 34 edges after start; busy high for cycles 1..33.
- Signed:
  - -7 / 2 -> quotient=-3 (0xFFFFFFFD), remainder=-1.
  - 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero: A=0x1234, B=0 -> exc=1, quotient=0, remainder=0x1234, rdy one cycle after start.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, exc=1.
- Same operands unsigned -> quotient=0, remainder=0x80000000, exc=0.
- Start pulse during ITER with different operands -> ignored; first result unchanged.
- reset_n low mid-ITER -> outputs 0 immediately, no rdy; a new start afterwards completes normally.
- WIDTH=8 run: 200 / 3 -> quotient=66, remainder=2, rdy 10 edges after start.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// divider_pkg: state encoding, default width and operand-magnitude helper shared by iterative_divider.
package divider_pkg;
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} div_state_t;
    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int ABS_W = 64;
    // value arrives sign-extended when signed_mode is set, zero-extended otherwise
    function automatic logic [ABS_W-1:0] abs_u(input logic [ABS_W-1:0] value, input logic signed_mode);
        return (signed_mode && value[ABS_W-1]) ? -value : value;
    endfunction
endpackage

// File: rtl/iterative_divider_div_step.sv
// div_step: one combinational restoring-division iteration on a double-width accumulator.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_next
);
    logic             borrow;
    logic [WIDTH-1:0] rem;
    always_comb begin
        {borrow, rem} = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, divisor};
        // the bit shifted out of the upper half means the partial remainder already exceeds the divisor
        acc_next = (acc[2*WIDTH-1] | ~borrow) ? {rem, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle restoring divider, one quotient bit per clock, signed/unsigned with exceptions.
// Define DIV_REMAINDER_EN to add the data_remainder output.
module iterative_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_quotient,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    div_state_t       state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d, quot_q, quot_d, mag_a, mag_b;
    logic             qneg_q, qneg_d, ovf_q, ovf_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             rneg_q, rneg_d;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (.acc(acc_q), .divisor(mag_b_q), .acc_next(acc_step));

    always_comb begin
        mag_a = WIDTH'(abs_u({{(ABS_W-WIDTH){ctrl_signed & data_operandA[WIDTH-1]}}, data_operandA}, ctrl_signed));
        mag_b = WIDTH'(abs_u({{(ABS_W-WIDTH){ctrl_signed & data_operandB[WIDTH-1]}}, data_operandB}, ctrl_signed));
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        mag_b_d = mag_b_q;
        qneg_d = qneg_q;
        ovf_d = ovf_q;
        quot_d = quot_q;
        exc_d = exc_q;
`ifdef DIV_REMAINDER_EN
        rem_d = rem_q;
        rneg_d = rneg_q;
`endif
        rdy_d = state_q == DONE;
        busy_d = state_q == ITER || state_q == FIXUP;
        case (state_q)
            IDLE: if (ctrl_div) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                cnt_d = '0;
                mag_b_d = mag_b;
                qneg_d = ctrl_signed & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                ovf_d = ctrl_signed & (data_operandA == MIN) & (&data_operandB);
                quot_d = '0;
                exc_d = data_operandB == '0;
`ifdef DIV_REMAINDER_EN
                rneg_d = ctrl_signed & data_operandA[WIDTH-1];
                rem_d = (data_operandB == '0) ? data_operandA : '0;
`endif
                state_d = (data_operandB == '0) ? DONE : ITER;
            end
            ITER: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIXUP : ITER;
            end
            FIXUP: begin
                // MIN / -1 wraps to MIN without special casing; only the flag is added
                quot_d = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                exc_d = ovf_q;
`ifdef DIV_REMAINDER_EN
                rem_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            mag_b_q <= '0;
            qneg_q <= 1'b0;
            ovf_q <= 1'b0;
            quot_q <= '0;
            exc_q <= 1'b0;
            rdy_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q <= '0;
            rneg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            mag_b_q <= mag_b_d;
            qneg_q <= qneg_d;
            ovf_q <= ovf_d;
            quot_q <= quot_d;
            exc_q <= exc_d;
            rdy_q <= rdy_d;
            busy_q <= busy_d;
`ifdef DIV_REMAINDER_EN
            rem_q <= rem_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    assign data_quotient = quot_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy = busy_q;
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: scoreboard bench for iterative_divider at WIDTH=32 and WIDTH=8.
module tb_iterative_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        div = 0, sg = 0, exc, rdy, busy;
    logic [31:0] a = 0, b = 0, q, r;
    logic        div8 = 0, sg8 = 0, e8, rdy8, busy8;
    logic [7:0]  a8 = 0, b8 = 0, q8, r8;

    iterative_divider #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .ctrl_div(div), .ctrl_signed(sg),
        .data_operandA(a), .data_operandB(b), .data_quotient(q),
`ifdef DIV_REMAINDER_EN
        .data_remainder(r),
`endif
        .data_exception(exc), .data_resultRDY(rdy), .busy(busy)
    );
    iterative_divider #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .ctrl_div(div8), .ctrl_signed(sg8),
        .data_operandA(a8), .data_operandB(b8), .data_quotient(q8),
`ifdef DIV_REMAINDER_EN
        .data_remainder(r8),
`endif
        .data_exception(e8), .data_resultRDY(rdy8), .busy(busy8)
    );
`ifndef DIV_REMAINDER_EN
    assign r = '0;
    assign r8 = '0;
`endif

    exp_t sb32[$], sb8[$];
    exp_t m32, m8;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clock) if (rdy === 1'b1) begin
        if (sb32.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rdy32_unexpected: got rdy=1 q=%h want no pulse", q);
        end else begin
            m32 = sb32.pop_front();
            chk("q32", q, m32.q);
            chk("exc32", {31'b0, exc}, {31'b0, m32.e});
`ifdef DIV_REMAINDER_EN
            chk("rem32", r, m32.r);
`endif
            chk("lat32", cyc - m32.acc, m32.lat);
        end
    end

    always @(negedge clock) if (rdy8 === 1'b1) begin
        if (sb8.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rdy8_unexpected: got rdy=1 q=%h want no pulse", q8);
        end else begin
            m8 = sb8.pop_front();
            chk("q8", {24'b0, q8}, m8.q);
            chk("exc8", {31'b0, e8}, {31'b0, m8.e});
`ifdef DIV_REMAINDER_EN
            chk("rem8", {24'b0, r8}, m8.r);
`endif
            chk("lat8", cyc - m8.acc, m8.lat);
        end
    end

    task automatic go32(input logic s, input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] eq,
                        input logic [31:0] er, input logic ee, input int lat, input bit push);
        exp_t x;
        div = 1;
        sg = s;
        a = aa;
        b = bb;
        if (push) begin
            x.q = eq; x.r = er; x.e = ee; x.lat = lat; x.acc = cyc + 1;
            sb32.push_back(x);
        end
        @(posedge clock);
        #1 div = 0;
    endtask

    task automatic go8(input logic s, input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] eq,
                       input logic [7:0] er, input logic ee);
        exp_t x;
        div8 = 1;
        sg8 = s;
        a8 = aa;
        b8 = bb;
        x.q = {24'b0, eq}; x.r = {24'b0, er}; x.e = ee; x.lat = 10; x.acc = cyc + 1;
        sb8.push_back(x);
        @(posedge clock);
        #1 div8 = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (sb32.size() != 0 || sb8.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d results pending want 0", name, sb32.size() + sb8.size());
            sb32.delete();
            sb8.delete();
        end
    endtask

    initial begin
        reset_n = 1;
        #2 reset_n = 0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_exc", {31'b0, exc}, 0);
        chk("rst_rdy", {31'b0, rdy}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rem", r, 0);
        chk("rst_q8", {24'b0, q8}, 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        @(negedge clock);

        go32(0, 100, 7, 14, 2, 0, 34, 1);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clock);
            #1 chk($sformatf("busy_k%0d", k), {31'b0, busy}, {31'b0, k <= 33});
        end
        drain("u100_7");
        @(posedge clock);
        #1 chk("hold_q", q, 14);

        go32(1, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34, 1);
        chk("clear_on_start", q, 0);
        drain("sm7_2");
        go32(1, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 34, 1);
        drain("s7_m2");
        go32(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 14, 32'hFFFFFFFE, 0, 34, 1);
        drain("sm100_m7");
        go32(0, 32'h1234, 0, 0, 32'h1234, 1, 1, 1);
        drain("divzero");
        go32(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 34, 1);
        drain("ovf");
        go32(0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 34, 1);
        drain("umin_max");
        go32(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 1, 0, 34, 1);
        drain("ubig");

        go32(0, 1000, 10, 100, 0, 0, 34, 1);
        repeat (5) @(negedge clock);
        go32(1, 55, 5, 0, 0, 0, 0, 0);
        drain("ignored_start");

        go32(0, 50, 5, 10, 0, 0, 34, 1);
        for (int n = 0; n < 100 && rdy !== 1'b1; n++) begin
            @(posedge clock);
            #1;
        end
        go32(0, 9, 4, 2, 1, 0, 34, 1);
        drain("back_to_back");

        go32(0, 77, 3, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clock);
        chk("busy_pre_reset", {31'b0, busy}, 1);
        reset_n = 0;
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_q", q, 0);
        chk("abort_exc", {31'b0, exc}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1;
        repeat (40) @(negedge clock);
        go32(0, 100, 7, 14, 2, 0, 34, 1);
        drain("after_abort");

        @(negedge clock);
        go8(0, 200, 3, 66, 2, 0);
        drain("w8_200_3");
        go8(1, 8'h80, 8'hFF, 8'h80, 0, 1);
        drain("w8_ovf");
        go8(1, 8'hF9, 2, 8'hFD, 8'hFF, 0);
        drain("w8_sm7_2");

        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
